hnf_txreq_arb: RTL and testbench

//  Parametrised HN-F TXREQ link-layer transmitter. Merges NUM_SRC internal request sources into one CHI TXREQ channel.

---
 rtl/chi_cache_pkg.sv | 30 +++
 rtl/hnf_txreq_arb_rr_arb.sv | 36 +++
 rtl/hnf_txreq_arb.sv | 124 ++++++++++++
 tb/tb_hnf_txreq_arb.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/chi_cache_pkg.sv
// Shared CHI TXREQ types: request flit layout, link-layer state encoding and
// the credit-return flit used when the TX link is being deactivated.
package chi_cache_pkg;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [7:0]  txn_id;
        logic [6:0]  src_id;
        logic [6:0]  tgt_id;
        logic [31:0] addr;
    } reqflit_t;

    localparam logic [5:0] REQ_LCRDRETURN = 6'h00;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        RETURN,
        DONE
    } txlnk_state_e;

    // A link flit that hands one L-credit back to the receiver.
    function automatic reqflit_t lcrd_return_flit();
        reqflit_t f;
        f        = '0;
        f.opcode = REQ_LCRDRETURN;
        return f;
    endfunction

endpackage

// File: rtl/hnf_txreq_arb_rr_arb.sv
// Combinational round-robin picker: searches from ptr+1 upward (mod N) and
// returns the first requesting index; the pointer register lives in the parent.
module rr_arb #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_gnt
            assign gnt[gi] = en && found && (gnt_idx == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/hnf_txreq_arb.sv
// HN-F TXREQ link transmitter: round-robin merge of NUM_SRC request sources,
// L-credit gated issue, and credit return on link deactivation.
module hnf_txreq_arb
    import chi_cache_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int MAX_CRD = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_valid,
    input  reqflit_t           src_flit [NUM_SRC],
    output logic [NUM_SRC-1:0] src_ready,
    input  logic               link_deact_req,
    output logic               link_deact_done,
    output logic               crd_overflow,
    output reqflit_t           TXREQFLIT,
    output logic               TXREQFLITV,
    output logic               TXREQFLITPEND,
    input  logic               TXREQLCRDV
);

    localparam int CW = $clog2(MAX_CRD + 1);
    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    txlnk_state_e  state_reg, state_next;
    logic [CW-1:0] crd_cnt_reg, crd_cnt_next;
    logic [IW-1:0] rr_ptr_reg;
    reqflit_t      flit_reg;
    logic          flitv_reg;
    logic          done_reg;
    logic          ovf_reg;
    logic          ovf_set;

    logic          have_crd;
    logic          grant_en;
    logic          return_issue;
    logic          src_issue;
    logic          issue;
    logic [NUM_SRC-1:0] gnt;
    logic [IW-1:0] gnt_idx;

    rr_arb #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_rr_arb (
        .req     (src_valid),
        .ptr     (rr_ptr_reg),
        .en      (grant_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            RUN:    if (link_deact_req) state_next = DRAIN;
            DRAIN:  if (!flitv_reg) state_next = RETURN;
            // A credit landing this cycle keeps us here so it is returned too.
            RETURN: if (!have_crd && !flitv_reg && !TXREQLCRDV) state_next = DONE;
            DONE:   if (!link_deact_req) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        have_crd     = (crd_cnt_reg != '0);
        grant_en     = 1'b0;
        return_issue = 1'b0;
        unique case (state_reg)
            RUN:     grant_en     = have_crd && !link_deact_req;
            RETURN:  return_issue = have_crd;
            default: ;
        endcase
        src_issue = grant_en && (|src_valid);
        issue     = src_issue || return_issue;
    end

    // Credit consumed and granted in the same cycle cancel out.
    always_comb begin
        crd_cnt_next = crd_cnt_reg;
        ovf_set      = 1'b0;
        if (TXREQLCRDV && !issue) begin
            if (crd_cnt_reg == CW'(MAX_CRD)) ovf_set = 1'b1;
            else                             crd_cnt_next = crd_cnt_reg + CW'(1);
        end else if (!TXREQLCRDV && issue) begin
            crd_cnt_next = crd_cnt_reg - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            crd_cnt_reg <= '0;
            rr_ptr_reg  <= IW'(NUM_SRC - 1);
            flit_reg    <= '0;
            flitv_reg   <= 1'b0;
            done_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            crd_cnt_reg <= crd_cnt_next;
            flitv_reg   <= issue;
            done_reg    <= (state_next == DONE);
            if (ovf_set) ovf_reg <= 1'b1;
            if (src_issue) rr_ptr_reg <= gnt_idx;
            if (issue) flit_reg <= return_issue ? lcrd_return_flit() : src_flit[gnt_idx];
        end
    end

    assign src_ready       = gnt;
    assign TXREQFLITPEND   = issue;
    assign TXREQFLIT       = flit_reg;
    assign TXREQFLITV      = flitv_reg;
    assign link_deact_done = done_reg;
    assign crd_overflow    = ovf_reg;

endmodule

// File: tb/tb_hnf_txreq_arb.sv
// Bench for hnf_txreq_arb: per-cycle vector table for grants/pend/done, and a
// flit scoreboard filled at issue time and drained when TXREQFLITV is seen.
module tb_hnf_txreq_arb;
    import chi_cache_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] src_valid = '0;
    reqflit_t   src_flit [2];
    logic [1:0] src_ready;
    logic       link_deact_req = 1'b0;
    logic       link_deact_done;
    logic       crd_overflow;
    reqflit_t   TXREQFLIT;
    logic       TXREQFLITV;
    logic       TXREQFLITPEND;
    logic       TXREQLCRDV = 1'b0;

    hnf_txreq_arb #(
        .NUM_SRC (2),
        .MAX_CRD (15)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .src_valid       (src_valid),
        .src_flit        (src_flit),
        .src_ready       (src_ready),
        .link_deact_req  (link_deact_req),
        .link_deact_done (link_deact_done),
        .crd_overflow    (crd_overflow),
        .TXREQFLIT       (TXREQFLIT),
        .TXREQFLITV      (TXREQFLITV),
        .TXREQFLITPEND   (TXREQFLITPEND),
        .TXREQLCRDV      (TXREQLCRDV)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [1:0] valid;
        logic       lcrdv;
        logic       deact;
        logic [1:0] exp_ready;
        logic       exp_pend;
        logic       exp_done;
    } vec_t;

    vec_t     vecs [$];
    reqflit_t exp_q [$];
    reqflit_t ret_flit;
    reqflit_t last_seen;
    reqflit_t mon_exp;
    int       tests = 0;
    int       fails = 0;
    int       seq   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One cycle: drive, check combinational/registered status, queue expected flit.
    task automatic apply(input string name, input logic [1:0] v, input logic l, input logic d,
                         input logic [1:0] er, input logic ep, input logic ed);
        seq++;
        for (int i = 0; i < 2; i++) begin
            src_flit[i].opcode = 6'h04;
            src_flit[i].txn_id = 8'(seq * 2 + i);
            src_flit[i].src_id = 7'(i + 1);
            src_flit[i].tgt_id = 7'h20;
            src_flit[i].addr   = (32'(seq) << 6) | 32'(i);
        end
        src_valid      = v;
        TXREQLCRDV     = l;
        link_deact_req = d;
        #1;
        chk({name, ".ready"}, 64'(src_ready), 64'(er));
        chk({name, ".pend"}, 64'(TXREQFLITPEND), 64'(ep));
        chk({name, ".done"}, 64'(link_deact_done), 64'(ed));
        if (ep) begin
            if (er[0])      exp_q.push_back(src_flit[0]);
            else if (er[1]) exp_q.push_back(src_flit[1]);
            else            exp_q.push_back(ret_flit);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic add(input string n, input logic [1:0] v, input logic l, input logic d,
                       input logic [1:0] er, input logic ep, input logic ed);
        vec_t r;
        r.name = n; r.valid = v; r.lcrdv = l; r.deact = d;
        r.exp_ready = er; r.exp_pend = ep; r.exp_done = ed;
        vecs.push_back(r);
    endtask

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i].name, vecs[i].valid, vecs[i].lcrdv, vecs[i].deact,
                  vecs[i].exp_ready, vecs[i].exp_pend, vecs[i].exp_done);
        vecs.delete();
    endtask

    always @(negedge clock) begin
        if (TXREQFLITV === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL flitv_unexpected: got flit 0x%0h, want no flit", TXREQFLIT);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("[TB] flit opcode=0x%0h txn=0x%0h src=%0d", TXREQFLIT.opcode,
                         TXREQFLIT.txn_id, TXREQFLIT.src_id);
                chk("txreqflit", 64'(TXREQFLIT), 64'(mon_exp));
            end
            last_seen = TXREQFLIT;
        end else if (reset) begin
            chk("flit_hold", 64'(TXREQFLIT), 64'(last_seen));
        end
        if (!reset) last_seen = '0;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        ret_flit        = '0;
        ret_flit.opcode = REQ_LCRDRETURN;
        last_seen       = '0;
        src_flit[0]     = '0;
        src_flit[1]     = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        chk("rst.flitv", 64'(TXREQFLITV), 64'(0));
        chk("rst.flit", 64'(TXREQFLIT), 64'(0));
        chk("rst.done", 64'(link_deact_done), 64'(0));
        chk("rst.ovf", 64'(crd_overflow), 64'(0));

        // No credits: nothing may be granted.
        for (int i = 0; i < 20; i++) apply("t1_nocrd", 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // Three credits, then both sources held valid.
        add("t2_crd_a", 2'b00, 1, 0, 2'b00, 0, 0);
        add("t2_crd_b", 2'b00, 1, 0, 2'b00, 0, 0);
        add("t2_crd_c", 2'b00, 1, 0, 2'b00, 0, 0);
        add("t2_g0",    2'b11, 0, 0, 2'b01, 1, 0);
        add("t2_g1",    2'b11, 0, 0, 2'b10, 1, 0);
        add("t2_g2",    2'b11, 0, 0, 2'b01, 1, 0);
        add("t2_empty", 2'b11, 0, 0, 2'b00, 0, 0);
        add("t2_empty", 2'b11, 0, 0, 2'b00, 0, 0);
        // Credit in and flit out together leave the count at one.
        add("t3_crd",   2'b00, 1, 0, 2'b00, 0, 0);
        add("t3_both",  2'b01, 1, 0, 2'b01, 1, 0);
        add("t3_last",  2'b10, 0, 0, 2'b10, 1, 0);
        add("t3_empty", 2'b10, 0, 0, 2'b00, 0, 0);
        run_vecs();
        chk("t2.crd_cnt", 64'(dut.crd_cnt_reg), 64'(0));

        for (int i = 0; i < 15; i++) apply("t3_fill", 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("t3.crd15", 64'(dut.crd_cnt_reg), 64'(15));
        chk("t3.ovf_before", 64'(crd_overflow), 64'(0));
        apply("t3_ovf", 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("t3.crd_sat", 64'(dut.crd_cnt_reg), 64'(15));
        chk("t3.ovf_after", 64'(crd_overflow), 64'(1));

        for (int i = 0; i < 10; i++) apply("t4_use", 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);

        // Deactivate with 4 credits left after the in-flight src0 flit.
        add("t4_issue",  2'b01, 0, 0, 2'b01, 1, 0);
        add("t4_deact",  2'b01, 0, 1, 2'b00, 0, 0);
        add("t4_drain",  2'b01, 0, 1, 2'b00, 0, 0);
        add("t4_ret0",   2'b01, 0, 1, 2'b00, 1, 0);
        add("t4_ret1",   2'b01, 0, 1, 2'b00, 1, 0);
        add("t4_ret2",   2'b01, 0, 1, 2'b00, 1, 0);
        add("t4_ret3",   2'b01, 0, 1, 2'b00, 1, 0);
        add("t4_tail",   2'b01, 0, 1, 2'b00, 0, 0);
        add("t4_tail",   2'b01, 0, 1, 2'b00, 0, 0);
        add("t4_done",   2'b01, 0, 1, 2'b00, 0, 1);
        add("t4_done",   2'b01, 0, 1, 2'b00, 0, 1);
        // Reactivate: credits arriving in DONE are kept.
        add("t5_react",  2'b10, 1, 0, 2'b00, 0, 1);
        add("t5_grant",  2'b10, 1, 0, 2'b10, 1, 0);
        add("t5_idle",   2'b00, 0, 0, 2'b00, 0, 0);
        run_vecs();

        // Reset with a flit in the output register and 5 credits held.
        for (int i = 0; i < 5; i++) apply("t6_crd", 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        apply("t6_issue", 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
        reset     = 1'b0;
        src_valid = 2'b00;
        #1;
        chk("t6.pre_flitv", 64'(TXREQFLITV), 64'(1));
        chk("t6.pre_crd", 64'(dut.crd_cnt_reg), 64'(5));
        @(posedge clock);
        #1;
        chk("t6.flitv", 64'(TXREQFLITV), 64'(0));
        chk("t6.flit", 64'(TXREQFLIT), 64'(0));
        chk("t6.pend", 64'(TXREQFLITPEND), 64'(0));
        chk("t6.ready", 64'(src_ready), 64'(0));
        chk("t6.done", 64'(link_deact_done), 64'(0));
        chk("t6.ovf", 64'(crd_overflow), 64'(0));
        chk("t6.crd", 64'(dut.crd_cnt_reg), 64'(0));
        chk("t6.rr_ptr", 64'(dut.rr_ptr_reg), 64'(1));
        reset = 1'b1;
        apply("t6_lost", 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        apply("t6_lost", 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        apply("t6_crd1", 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        apply("t6_src0", 2'b11, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
        apply("t6_idle", 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
